// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: drives d/s, samples y each step, serialises and recaptures the word.
// Optional MUX_SCAN_CHECK_EN builds a sticky compare of y_in against d_out[s] onto err.
module mux8_scan_ctrl #(
    parameter int SEL_W = 3,
    parameter int HOLD  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2**SEL_W-1:0]   d_in,
    output logic [2**SEL_W-1:0]   d_out,
    output logic [SEL_W-1:0]      s,
    input  logic                  y_in,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic [2**SEL_W-1:0]   capture,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int N = 2**SEL_W;
    localparam logic [3:0]       HOLD_LAST = 4'(HOLD - 1);
    localparam logic [SEL_W-1:0] S_LAST    = SEL_W'(N - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     d_out_q, d_out_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     capture_q, capture_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef MUX_SCAN_CHECK_EN
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        d_out_d     = d_out_q;
        s_d         = s_q;
        hold_cnt_d  = hold_cnt_q;
        capture_d   = capture_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef MUX_SCAN_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    d_out_d    = d_in;
                    s_d        = '0;
                    hold_cnt_d = '0;
                    capture_d  = '0;
                    busy_d     = 1'b1;
`ifdef MUX_SCAN_CHECK_EN
                    err_d      = 1'b0;
`endif
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // Sample on the last cycle of each select's hold window.
                if (hold_cnt_q == HOLD_LAST) begin
                    capture_d[s_q] = y_in;
                    ser_out_d      = y_in;
                    ser_valid_d    = 1'b1;
`ifdef MUX_SCAN_CHECK_EN
                    if (y_in != d_out_q[s_q]) begin
                        err_d = 1'b1;
                    end
`endif
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        s_d        = s_q + SEL_W'(1);
                        hold_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_out_q     <= '0;
            s_q         <= '0;
            hold_cnt_q  <= '0;
            capture_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MUX_SCAN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            d_out_q     <= d_out_d;
            s_q         <= s_d;
            hold_cnt_q  <= hold_cnt_d;
            capture_q   <= capture_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MUX_SCAN_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign d_out     = d_out_q;
    assign s         = s_q;
    assign capture   = capture_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef MUX_SCAN_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: two instances (HOLD=1 and HOLD=3) each feeding a behavioural 8:1 mux,
// checked cycle by cycle against timing derived from the scan rules with plain arithmetic.
module tb_mux8_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d_in;
    logic [1:0] start_v, y_v, ser_out_v, ser_valid_v, busy_v, done_v, err_v, inj_v;
    logic [7:0] d_out_a [2];
    logic [2:0] s_a [2];
    logic [7:0] cap_a [2];
    int         tests = 0;
    int         fails = 0;

`ifdef MUX_SCAN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    // Behavioural mux8 with an optional inversion fault on input 5.
    assign y_v[0] = d_out_a[0][s_a[0]] ^ (inj_v[0] && s_a[0] == 3'd5);
    assign y_v[1] = d_out_a[1][s_a[1]] ^ (inj_v[1] && s_a[1] == 3'd5);

    mux8_scan_ctrl #(.SEL_W(3), .HOLD(1)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .d_in(d_in),
        .d_out(d_out_a[0]), .s(s_a[0]), .y_in(y_v[0]),
        .ser_out(ser_out_v[0]), .ser_valid(ser_valid_v[0]), .capture(cap_a[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0])
    );

    mux8_scan_ctrl #(.SEL_W(3), .HOLD(3)) dut_h3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .d_in(d_in),
        .d_out(d_out_a[1]), .s(s_a[1]), .y_in(y_v[1]),
        .ser_out(ser_out_v[1]), .ser_valid(ser_valid_v[1]), .capture(cap_a[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // {d_out, s, ser_valid, ser_out (qualified), done, busy, err}
    function automatic logic [15:0] snap(input int w);
        return {d_out_a[w], s_a[w], ser_valid_v[w], ser_valid_v[w] & ser_out_v[w],
                done_v[w], busy_v[w], err_v[w]};
    endfunction

    // Run one scan; intrude >= 0 raises start (d_in=FF) just before edge intrude+1 after accept.
    task automatic applyStimulus(input int w, input logic [7:0] word, input bit inject, input int intrude);
        int hold, total, step, k;
        bit vld, bitv, ex_done, ex_busy, ex_err;
        logic [2:0] ex_s;
        hold  = (w == 1) ? 3 : 1;
        total = 8 * hold;
        inj_v[w]   = inject;
        start_v[w] = 1'b1;
        d_in       = word;
        @(posedge clk); #1;
        start_v[w] = 1'b0;
        d_in       = 8'($urandom);
        checkOutput("accept", 32'(snap(w)), 32'({word, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        checkOutput("accept_cap", 32'(cap_a[w]), 32'h0);
        for (int c = 1; c <= total + 1; c++) begin
            if (c - 1 == intrude) begin
                start_v[w] = 1'b1;
                d_in       = 8'hFF;
            end
            @(posedge clk); #1;
            start_v[w] = 1'b0;
            step    = c / hold;
            vld     = (c % hold == 0) && (c <= total);
            k       = step - 1;
            bitv    = vld ? (word[k & 7] ^ (inject && k == 5)) : 1'b0;
            ex_s    = (c >= total) ? 3'd7 : 3'(step);
            ex_done = (c == total);
            ex_busy = (c < total);
            ex_err  = CHK && inject && (c >= 6 * hold);
            checkOutput($sformatf("scan_w%0d_c%0d", w, c), 32'(snap(w)),
                        32'({word, ex_s, vld, bitv, ex_done, ex_busy, ex_err}));
        end
        checkOutput("capture", 32'(cap_a[w]), 32'(word ^ (inject ? 8'h20 : 8'h00)));
        inj_v[w] = 1'b0;
    endtask

    // Abort a scan with reset once s reaches 4; no done pulse may follow.
    task automatic midReset(input int w, input logic [7:0] word);
        int hold, dones;
        hold = (w == 1) ? 3 : 1;
        start_v[w] = 1'b1;
        d_in       = word;
        @(posedge clk); #1;
        start_v[w] = 1'b0;
        repeat (4 * hold) @(posedge clk);
        #1;
        checkOutput("pre_reset_s", 32'(s_a[w]), 32'd4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("reset_snap", 32'(snap(w)), 32'h0);
        checkOutput("reset_cap", 32'(cap_a[w]), 32'h0);
        dones = 0;
        for (int c = 0; c < 10 * hold; c++) begin
            @(posedge clk); #1;
            if (done_v[w] || busy_v[w]) dones++;
        end
        checkOutput("no_done_after_reset", 32'(dones), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] w8;
        int         w, intr;
        inj_v   = 2'b00;
        rst_n   = 1'b0;
        start_v = 2'b11;
        d_in    = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_state", 32'(snap(i)), 32'h0);
            checkOutput("reset_cap", 32'(cap_a[i]), 32'h0);
        end
        start_v = 2'b00;
        rst_n   = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_after_reset", 32'(snap(0)), 32'h0);

        applyStimulus(0, 8'hA6, 1'b0, -1);
        applyStimulus(0, 8'h3C, 1'b0, 3);
        applyStimulus(0, 8'h77, 1'b0, 8);
        midReset(0, 8'hC3);
        applyStimulus(0, 8'h01, 1'b0, -1);
        applyStimulus(1, 8'h5A, 1'b0, -1);
        applyStimulus(1, 8'h3C, 1'b0, 24);
        applyStimulus(0, 8'hF0, 1'b1, -1);
        applyStimulus(0, 8'h96, 1'b0, -1);
        applyStimulus(1, 8'hF0, 1'b1, -1);
        applyStimulus(1, 8'h0F, 1'b0, -1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_keeps_cap", 32'(cap_a[0]), 32'h96);
        checkOutput("idle_keeps_cap3", 32'(cap_a[1]), 32'h0F);

        for (int i = 0; i < 10; i++) begin
            w    = int'($urandom_range(0, 1));
            w8   = 8'($urandom);
            intr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8 * ((w == 1) ? 3 : 1))) : -1;
            applyStimulus(w, w8, 1'($urandom_range(0, 1)), intr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux8_scan_ctrl.md
Name: mux8_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 8:1 mux (mux8) and drives its data and select inputs. On a start request it latches an 8-bit word, presents it on the mux data bus and steps the select 0..7. It samples the mux output at each step and emits the bits LSB-first as a serial stream. It also reassembles the sampled bits into a capture word. It gives the team a clocked, self-checking consumer/driver for the combinational mux path.

Parameters:
SEL_W, 3, select width; number of mux inputs N = 2**SEL_W (8 at default).
HOLD, 1, clock cycles each select value is held (legal range 1..15).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset (sampled on clk rising edge).
start  input  1  request to begin a scan; honoured only in IDLE.
d_in  input  N  word to scan; sampled on the accepting edge.
d_out  output  N  registered word driven to mux d input.
s  output  SEL_W  registered select driven to mux s input.
y_in  input  1  mux y output, combinational from d_out/s.
ser_out  output  1  sampled mux bit.
ser_valid  output  1  ser_out qualifier, 1 cycle per step.
capture  output  N  reassembled word; bit k = y_in sampled while s==k.
busy  output  1  high from accept until the done cycle (exclusive).
done  output  1  1-cycle pulse after the last step.
err  output  1  sticky mismatch flag (see Optional Feature).

Behaviour:
- Reset (rst_n==0 at an edge): state=IDLE. d_out, s, capture, ser_out, ser_valid, busy, done and err all go to 0. The hold counter clears.
- Reset mid-scan aborts immediately. No done pulse follows, and capture reads 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start==1 at edge E0: d_out<=d_in, s<=0, hold_cnt<=0, capture<=0, busy<=1, err<=0, next state SCAN.
- IDLE, start==0: stay in IDLE; all outputs hold their values (capture keeps the last result).
- SCAN: hold_cnt counts 0..HOLD-1. On the edge where hold_cnt==HOLD-1:
  - capture[s]<=y_in, ser_out<=y_in, ser_valid<=1 for the following cycle.
  - If s==N-1: next state DONE; s stays at N-1.
  - Else: s<=s+1 and hold_cnt<=0.
  - ser_valid is 0 on all other cycles.
- DONE: done=1 and busy=0 for exactly 1 cycle, then unconditionally IDLE.
  - A start asserted during the DONE cycle is ignored; start must be seen in IDLE.
- start is ignored while busy. d_in changes after E0 have no effect; d_out is stable for the whole scan.
- Timing for HOLD=1: samples at edges E1..E8, ser_valid high in cycles 2..9, DONE state in cycle 9 (done visible after E8).
- General timing: done rises N*HOLD edges after E0.
- Back-to-back scans are possible with start asserted in the cycle after done. Minimum period is N*HOLD+2 cycles.
- s never wraps past N-1. No arithmetic overflow: hold_cnt width is 4 bits.
- y_in equal to x/z is captured as-is; no X-masking.

Optional Feature:
Macro MUX_SCAN_CHECK_EN.
- Defined: at each sample edge compare y_in with d_out[s]. On mismatch, err<=1, sticky until reset or the next accepted start.
- Undefined: err is tied to constant 0 and no compare logic is built.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with start=1 and d_in=8'hFF -> all outputs 0, state IDLE, no scan begins.
2. Basic scan: HOLD=1, with the bench instantiating mux8 between d_out/s and y_in. Pulse start with d_in=8'hA6 ->
   - s steps 0..7 on consecutive cycles;
   - ser_out on the ser_valid cycles = 0,1,1,0,0,1,0,1;
   - done pulses 8 edges after accept, with capture=8'hA6, busy=0, err=0.
3. Start while busy: issue start with d_in=8'h3C, then start again with d_in=8'hFF at step 3 -> second start ignored, d_out stays 8'h3C, capture=8'h3C, exactly one done pulse.
4. Reset mid-scan: drop rst_n when s==4 -> next edge s=0, busy=0, capture=0, no done pulse. A start afterwards with 8'h01 completes normally with capture=8'h01.
5. HOLD=3: start with d_in=8'h5A -> each s value held 3 cycles, done 24 edges after accept, capture=8'h5A.
6. MUX_SCAN_CHECK_EN defined: start with d_in=8'hF0 while the bench forces y_in inverted when s==5 ->
   - capture=8'hD0 and err=1 from the sample at s==5 onward;
   - err clears on the next accepted start.
   With the macro undefined, the same stimulus gives err=0 throughout.
